// File: rtl/pia_uart_ctrl_if.sv
// CPU-side register bus between the 6502 bus decode and pia_uart_ctrl.
// The master drives one access strobe per bus cycle; the slave returns registered read data.
interface pia_uart_ctrl_if;
    logic       acc;
    logic       rw;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    modport master (output acc, output rw, output addr, output wdata, input rdata);
    modport slave  (input acc, input rw, input addr, input wdata, output rdata);
endinterface

// File: rtl/pia_uart_ctrl.sv
// PIA-style UART controller: RX FIFO with CTS flow control, and a double-buffered
// TX holding register feeding a transmit sequencer for the uart core.
module pia_uart_ctrl #(
    parameter int unsigned RX_AW      = 4,
    parameter int unsigned CTS_MARGIN = 2
) (
    input  logic                 clk,
    input  logic                 res,
    pia_uart_ctrl_if.slave       bus,
    input  logic                 received,
    input  logic [7:0]           rx_byte,
    input  logic                 is_transmitting,
    output logic                 transmit,
    output logic [6:0]           tx_byte,
    output logic                 uart_cts
);
    localparam int unsigned DEPTH = 1 << RX_AW;
    localparam logic [RX_AW:0] FULL_LEVEL = (RX_AW + 1)'(DEPTH);
    localparam logic [RX_AW:0] CTS_LEVEL  = (RX_AW + 1)'(DEPTH - CTS_MARGIN);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } tx_state_e;

    logic [6:0]       mem_q [DEPTH];
    logic [RX_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [RX_AW:0]   level_q, level_d;
    logic             rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
    logic             cts_q, cts_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             hold_full_q, hold_full_d;
    logic [6:0]       hold_data_q, hold_data_d;
    logic [6:0]       tx_byte_q, tx_byte_d;
    logic [1:0]       wait_cnt_q, wait_cnt_d;
    tx_state_e        state_q, state_d;

    logic             rd_acc, wr_acc, empty, full, push, pop;
    logic [31:0]      level_ext;
    logic [4:0]       level_sat;
    logic             unused_bits;

    assign unused_bits = ^{bus.wdata[7], rx_byte[7]};

    always_comb begin
        rd_acc    = bus.acc & bus.rw;
        wr_acc    = bus.acc & ~bus.rw;
        empty     = (level_q == '0);
        full      = (level_q == FULL_LEVEL);
        pop       = rd_acc && (bus.addr == 2'd0) && !empty;
        // A pop on a full FIFO frees the slot the simultaneous push lands in.
        push      = received && (!full || pop);
        level_ext = 32'(level_q);
        level_sat = (level_ext > 32'd31) ? 5'd31 : level_ext[4:0];

        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d   = level_q;
        if (push && !pop) level_d = level_q + 1'b1;
        if (pop && !push) level_d = level_q - 1'b1;
        cts_d     = (level_q >= CTS_LEVEL);

        rdata_d     = rdata_q;
        rx_ovf_d    = rx_ovf_q;
        tx_ovf_d    = tx_ovf_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        tx_byte_d   = tx_byte_q;
        wait_cnt_d  = wait_cnt_q;
        state_d     = state_q;

        if (rd_acc) begin
            case (bus.addr)
                2'd0:    rdata_d = empty ? 8'h00 : {1'b1, mem_q[rd_ptr_q]};
                2'd1:    rdata_d = {~empty, 7'b0};
                2'd2:    rdata_d = {hold_full_q, 7'b0};
                default: begin
                    rdata_d  = {rx_ovf_q, tx_ovf_q, 1'b0, level_sat};
                    rx_ovf_d = 1'b0;
                    tx_ovf_d = 1'b0;
                end
            endcase
        end

        if (received && full && !pop) rx_ovf_d = 1'b1;

        case (state_q)
            TX_IDLE: begin
                if (hold_full_q && !is_transmitting) begin
                    state_d   = TX_START;
                    tx_byte_d = hold_data_q;
                end
            end
            TX_START: begin
                hold_full_d = 1'b0;
                wait_cnt_d  = '0;
                state_d     = TX_WAIT_BUSY;
            end
            TX_WAIT_BUSY: begin
                if (is_transmitting) begin
                    state_d = TX_WAIT_DONE;
                end else if (wait_cnt_q == 2'd3) begin
                    state_d  = TX_IDLE;
                    tx_ovf_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                if (!is_transmitting) state_d = TX_IDLE;
            end
        endcase

        // A write during START lands in the register START is vacating.
        if (wr_acc && (bus.addr == 2'd2)) begin
            if (!hold_full_q || (state_q == TX_START)) begin
                hold_full_d = 1'b1;
                hold_data_d = bus.wdata[6:0];
            end else begin
                tx_ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rx_byte[6:0];
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            rx_ovf_q    <= 1'b0;
            tx_ovf_q    <= 1'b0;
            cts_q       <= 1'b0;
            rdata_q     <= '0;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            tx_byte_q   <= '0;
            wait_cnt_q  <= '0;
            state_q     <= TX_IDLE;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            rx_ovf_q    <= rx_ovf_d;
            tx_ovf_q    <= tx_ovf_d;
            cts_q       <= cts_d;
            rdata_q     <= rdata_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            tx_byte_q   <= tx_byte_d;
            wait_cnt_q  <= wait_cnt_d;
            state_q     <= state_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign transmit  = (state_q == TX_START);
    assign tx_byte   = tx_byte_q;
    assign uart_cts  = cts_q;
endmodule

// File: tb/tb_pia_uart_ctrl.sv
// Directed bench for pia_uart_ctrl: register reads, RX FIFO/CTS/overflow, TX sequencing.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pia_uart_ctrl;
    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       received = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       is_transmitting = 1'b0;
    logic       transmit;
    logic [6:0] tx_byte;
    logic       uart_cts;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    int unsigned uart_mode = 0;  // 0: busy 20 cycles per byte, 1: never busy
    int unsigned busy_cnt  = 0;
    int unsigned tx_count  = 0;
    logic [6:0]  tx_last   = 7'h00;

    pia_uart_ctrl_if bus_if ();

    pia_uart_ctrl #(.RX_AW(4), .CTS_MARGIN(2)) dut (
        .clk             (clk),
        .res             (res),
        .bus             (bus_if.slave),
        .received        (received),
        .rx_byte         (rx_byte),
        .is_transmitting (is_transmitting),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .uart_cts        (uart_cts)
    );

    always #5 clk = ~clk;

    // UART core stand-in
    always @(posedge clk) begin
        if (transmit) begin
            tx_count <= tx_count + 1;
            tx_last  <= tx_byte;
        end
        if (transmit && uart_mode == 0) begin
            is_transmitting <= 1'b1;
            busy_cnt        <= 20;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else if (busy_cnt == 1) begin
            busy_cnt        <= 0;
            is_transmitting <= 1'b0;
        end
    end

    task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        bus_if.acc = 1'b1; bus_if.rw = 1'b1; bus_if.addr = a;
        @(negedge clk);
        bus_if.acc = 1'b0;
        d = bus_if.rdata;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] v);
        @(negedge clk);
        bus_if.acc = 1'b1; bus_if.rw = 1'b0; bus_if.addr = a; bus_if.wdata = v;
        @(negedge clk);
        bus_if.acc = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        received = 1'b1; rx_byte = b;
        @(negedge clk);
        received = 1'b0;
    endtask

    task automatic push_and_pop(input logic [7:0] b, output logic [7:0] d);
        @(negedge clk);
        received = 1'b1; rx_byte = b;
        bus_if.acc = 1'b1; bus_if.rw = 1'b1; bus_if.addr = 2'd0;
        @(negedge clk);
        received = 1'b0; bus_if.acc = 1'b0;
        d = bus_if.rdata;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        res = 1'b0;
        repeat (3) @(negedge clk);
        res = 1'b1;
        total_cnt++;
        if (bus_if.rdata !== 8'h00) $display("FAIL reset_rdata got=%h exp=00", bus_if.rdata);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            cpu_read(2'(i), d);
            total_cnt++;
            if (d !== 8'h00) $display("FAIL reset_read addr=%0d got=%h exp=00", i, d);
            else pass_cnt++;
        end
        total_cnt++;
        if (uart_cts !== 1'b0 || transmit !== 1'b0 || tx_byte !== 7'h00)
            $display("FAIL reset_outputs cts=%b transmit=%b tx_byte=%h exp=0/0/00", uart_cts, transmit, tx_byte);
        else pass_cnt++;
    endtask

    task automatic test_rx_single();
        logic [7:0] d;
        logic [7:0] exp [3] = '{8'h80, 8'hC1, 8'h00};
        logic [1:0] adr [3] = '{2'd1, 2'd0, 2'd0};
        push(8'hC1);
        for (int i = 0; i < 3; i++) begin
            cpu_read(adr[i], d);
            total_cnt++;
            if (d !== exp[i]) $display("FAIL rx_single step=%0d got=%h exp=%h", i, d, exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_rx_empty_push_pop();
        logic [7:0] d;
        push_and_pop(8'h35, d);
        total_cnt++;
        if (d !== 8'h00) $display("FAIL empty_push_pop_read got=%h exp=00", d);
        else pass_cnt++;
        cpu_read(2'd0, d);
        total_cnt++;
        if (d !== 8'hB5) $display("FAIL empty_push_pop_byte got=%h exp=b5", d);
        else pass_cnt++;
    endtask

    task automatic test_rx_fill();
        logic [7:0] d;
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            if (i == 13) begin
                total_cnt++;
                if (uart_cts !== 1'b0) $display("FAIL cts_lag got=%b exp=0", uart_cts);
                else pass_cnt++;
            end
            @(negedge clk);
            total_cnt++;
            if (uart_cts !== (i >= 13)) $display("FAIL cts push=%0d got=%b exp=%b", i + 1, uart_cts, (i >= 13));
            else pass_cnt++;
        end
        push(8'h2A);
        cpu_read(2'd3, d);
        total_cnt++;
        if (d !== 8'h90) $display("FAIL status_ovf got=%h exp=90", d);
        else pass_cnt++;
        cpu_read(2'd3, d);
        total_cnt++;
        if (d !== 8'h10) $display("FAIL status_clear got=%h exp=10", d);
        else pass_cnt++;
    endtask

    task automatic test_rx_full_push_pop();
        logic [7:0] d;
        push_and_pop(8'h7A, d);
        total_cnt++;
        if (d !== 8'h80) $display("FAIL full_push_pop_read got=%h exp=80", d);
        else pass_cnt++;
        cpu_read(2'd3, d);
        total_cnt++;
        if (d !== 8'h10) $display("FAIL full_push_pop_status got=%h exp=10", d);
        else pass_cnt++;
        for (int i = 1; i < 17; i++) begin
            cpu_read(2'd0, d);
            total_cnt++;
            if (i < 16 && d !== 8'(8'h80 + i)) $display("FAIL drain idx=%0d got=%h exp=%h", i, d, 8'(8'h80 + i));
            else if (i == 16 && d !== 8'hFA) $display("FAIL drain_last got=%h exp=fa", d);
            else pass_cnt++;
        end
        cpu_read(2'd1, d);
        total_cnt++;
        if (d !== 8'h00) $display("FAIL drained_rxcr got=%h exp=00", d);
        else pass_cnt++;
    endtask

    task automatic wait_transmit(input string name);
        int unsigned n = 0;
        while (transmit !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (transmit !== 1'b1) $display("FAIL %s_timeout transmit=%b exp=1", name, transmit);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        uart_mode = 0;
        cpu_write(2'd2, 8'h41);
        total_cnt++;
        if (transmit !== 1'b0) $display("FAIL tx_latency_early transmit=%b exp=0", transmit);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (transmit !== 1'b1 || tx_byte !== 7'h41) $display("FAIL tx_first transmit=%b tx_byte=%h exp=1/41", transmit, tx_byte);
        else pass_cnt++;
        cpu_write(2'd2, 8'h42);
        cpu_read(2'd2, d);
        total_cnt++;
        if (d !== 8'h80) $display("FAIL tx_busy_flag got=%h exp=80", d);
        else pass_cnt++;
        cpu_write(2'd2, 8'h43);
        cpu_read(2'd3, d);
        total_cnt++;
        if (d !== 8'h40) $display("FAIL tx_ovf_status got=%h exp=40", d);
        else pass_cnt++;
        cpu_read(2'd2, d);
        total_cnt++;
        if (d !== 8'h80 || transmit !== 1'b0) $display("FAIL tx_held got=%h transmit=%b exp=80/0", d, transmit);
        else pass_cnt++;
        wait_transmit("tx_second");
        total_cnt++;
        if (tx_byte !== 7'h42) $display("FAIL tx_second_byte got=%h exp=42", tx_byte);
        else pass_cnt++;
        cpu_read(2'd2, d);
        total_cnt++;
        if (d !== 8'h00) $display("FAIL tx_hold_empty got=%h exp=00", d);
        else pass_cnt++;
        repeat (40) @(negedge clk);
        total_cnt++;
        if (tx_count !== 2 || tx_last !== 7'h42) $display("FAIL tx_pulse_count got=%0d/%h exp=2/42", tx_count, tx_last);
        else pass_cnt++;
    endtask

    task automatic test_tx_no_busy();
        logic [7:0] d;
        uart_mode = 1;
        cpu_write(2'd2, 8'h55);
        wait_transmit("stuck_start");
        total_cnt++;
        if (tx_byte !== 7'h55) $display("FAIL stuck_byte got=%h exp=55", tx_byte);
        else pass_cnt++;
        repeat (6) @(negedge clk);
        cpu_read(2'd3, d);
        total_cnt++;
        if (d !== 8'h40) $display("FAIL stuck_status got=%h exp=40", d);
        else pass_cnt++;
        cpu_write(2'd2, 8'h56);
        @(negedge clk);
        total_cnt++;
        if (transmit !== 1'b1 || tx_byte !== 7'h56) $display("FAIL stuck_back_idle transmit=%b tx_byte=%h exp=1/56", transmit, tx_byte);
        else pass_cnt++;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        bus_if.acc = 1'b0; bus_if.rw = 1'b0; bus_if.addr = 2'd0; bus_if.wdata = 8'h00;
        test_reset();
        test_rx_single();
        test_rx_empty_push_pop();
        test_rx_fill();
        test_rx_full_push_pop();
        test_back_to_back();
        test_tx_no_busy();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/pia_uart_ctrl.md
# pia_uart_ctrl

PIA-style UART controller between the 6502 bus decode and the `uart` core: an RX FIFO with hardware flow control, and a double-buffered TX path with a transmit sequencer. It replaces the single-byte RX flag/ack latch and the raw TX strobe, so the CPU never loses keystrokes under paste bursts and never has to hold the UART itself. It is clocked on the UART's master clock; the bus decode presents one access strobe per CPU bus cycle.

## Interface
- `RX_AW`, 4: RX FIFO address width; depth = 2^RX_AW entries of 7 bits.
- `CTS_MARGIN`, 2: free entries remaining at which `uart_cts` asserts.
- `clk`  in  1  master clock; all logic on rising edge.
- `res`  in  1  synchronous, active-low reset.
- `acc`  in  1  one-cycle access strobe from bus decode.
- `rw`  in  1  1 = read, 0 = write; sampled with `acc`.
- `addr`  in  2  register select: 0 RXDATA, 1 RXCR, 2 TXDATA, 3 STATUS.
- `wdata`  in  8  CPU write data; sampled with `acc`.
- `rdata`  out  8  registered read data.
- `received`  in  1  UART one-cycle "byte received" pulse.
- `rx_byte`  in  8  UART received byte; bit 7 discarded.
- `is_transmitting`  in  1  UART TX busy.
- `transmit`  out  1  one-cycle pulse to start a UART transmission.
- `tx_byte`  out  7  byte to transmit; stable from `transmit` until `is_transmitting` falls.
- `uart_cts`  out  1  1 = hold off sender.

## Operation
- Reads (`acc`=1, `rw`=1):
  - addr 0: non-empty -> `{1'b1, head}` and pop; empty -> 8'h00, no pop.
  - addr 1: `{~empty, 7'b0}`; no side effect.
  - addr 2: `{tx_busy, 7'b0}`; `tx_busy` = TX holding register full.
  - addr 3: `{rx_ovf, tx_ovf, 1'b0, level[4:0]}` (level saturates at 31); clears both sticky flags.
- Writes (`acc`=1, `rw`=0):
  - addr 2: holding empty -> load `wdata[6:0]`, set holding full; holding full -> byte dropped, set `tx_ovf`.
  - addr 0/1/3: ignored.
- RX path: `received`=1 with FIFO not full -> push `rx_byte[6:0]`. FIFO full -> drop, set `rx_ovf`.
- Level counter RX_AW+1 bits; pointers RX_AW bits, wrap at 2^RX_AW.
- `uart_cts` = registered (`level` >= 2^RX_AW - CTS_MARGIN).
- TX sequencer states:
  - IDLE: holding full and `is_transmitting`=0 -> START.
  - START: `transmit`=1 for this cycle; copy holding to `tx_byte`; clear holding. -> WAIT_BUSY.
  - WAIT_BUSY: `is_transmitting`=1 -> WAIT_DONE. After 4 cycles without it -> IDLE (byte lost, set `tx_ovf`).
  - WAIT_DONE: `is_transmitting`=0 -> IDLE.
- Holding may be reloaded while in WAIT_BUSY or WAIT_DONE. This double-buffering keeps back-to-back characters flowing.

## Timing
- Reset (`res`=0 at a clock edge): FIFO empty, pointers 0, `rdata`=8'h00, `transmit`=0, `tx_byte`=7'h00, `uart_cts`=0, both sticky flags 0, holding empty, state IDLE.
- Reset mid-transmission abandons the sequencer; the UART's own reset handles the line.
- `rdata` is valid on the cycle after `acc` and holds until the next read access.
- The pop takes effect on that same edge.
- Push visible via RXCR/STATUS one cycle after `received`.
- `uart_cts` lags level by one cycle; CTS_MARGIN ≥ 2 covers this.
- Simultaneous push and pop:
  - Non-empty FIFO: both happen; level unchanged.
  - Empty FIFO: push happens; the read returns 8'h00.
  - Full FIFO: pop happens first, so the push is accepted and `rx_ovf` stays clear.
- Write to addr 2 in the same cycle START clears the holding register: the write is accepted into the now-empty holding register.
- TX latency: write at cycle N -> `transmit` at N+2 when the UART is idle.

## Test plan
- Reset, then read all four registers -> 8'h00, 8'h00, 8'h00, 8'h00; `uart_cts`=0, `transmit`=0.
- Push 0xC1 via `received`, read addr 1 then addr 0 twice -> 8'h80, 8'hC1, 8'h00.
- Push 16 bytes 0x00..0x0F (RX_AW=4):
  - `uart_cts` rises after the 14th push.
  - A 17th push sets `rx_ovf`; STATUS reads 8'h90, then 8'h10.
  - Sixteen addr 0 reads return 8'h80..8'h8F in order.
- With FIFO full, pop and push in the same cycle -> no overflow; level stays 16; the new byte reads last.
- Write 0x41 then 0x42 back-to-back with a UART model busy 20 cycles:
  - `transmit` pulses with `tx_byte`=0x41.
  - addr 2 reads 8'h80 until the second START.
  - Second pulse carries 0x42.
  - A third write while busy sets `tx_ovf`.
- UART model never raises `is_transmitting` -> state returns to IDLE after 4 cycles; STATUS bit 6 set.
